// File: rtl/timer_led_periph_if.sv
// rtl/timer_led_periph_if.sv - req/gnt/rvalid data-port bus between the core and the peripheral
interface timer_led_periph_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/timer_led_periph.sv
// rtl/timer_led_periph.sv - LED register plus 64-bit prescaled machine timer with compare interrupt
module timer_led_periph #(
  parameter logic [31:0] BaseAddr    = 32'h0001_0000,
  parameter logic [15:0] PrescaleRst = 16'd0
) (
  input  logic                clk_sys,
  input  logic                rst_sys_n,
  timer_led_periph_if.slave   bus,
  output logic [3:0]          led_o,
  output logic                irq_timer_o
);

  localparam logic [9:0] OffLed    = 10'd0;
  localparam logic [9:0] OffMtLo   = 10'd1;
  localparam logic [9:0] OffMtHi   = 10'd2;
  localparam logic [9:0] OffCmpLo  = 10'd3;
  localparam logic [9:0] OffCmpHi  = 10'd4;
  localparam logic [9:0] OffCtrl   = 10'd5;
  localparam logic [9:0] OffPresc  = 10'd6;

  logic [3:0]  r_led;
  logic [63:0] r_mtime;
  logic [31:0] r_shadow;
  logic [63:0] r_cmp;
  logic [1:0]  r_ctrl;
  logic [15:0] r_prescale;
  logic [15:0] r_ps_cnt;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_irq;

  logic        w_sel;
  logic [9:0]  w_off;
  logic        w_hit_any;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_mt_lo;
  logic        w_wr_mt_hi;
  logic        w_wr_presc;
  logic        w_tick;
  logic [63:0] w_mtime_nxt;
  logic [15:0] w_ps_nxt;
  logic [31:0] w_rdata;
  logic        w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // sel is gated by reset so no grant is ever given while the block is held in reset
  assign w_sel     = rst_sys_n && bus.req_i && (bus.addr_i[31:12] == BaseAddr[31:12]);
  assign w_off     = bus.addr_i[11:2];
  assign w_hit_any = (w_off <= OffPresc);
  assign w_wr      = w_sel && bus.we_i && w_hit_any && (bus.be_i != 4'b0000);
  assign w_rd      = w_sel && !bus.we_i;
  assign w_wr_mt_lo = w_wr && (w_off == OffMtLo);
  assign w_wr_mt_hi = w_wr && (w_off == OffMtHi);
  assign w_wr_presc = w_wr && (w_off == OffPresc);
  assign w_unused  = ^bus.addr_i[1:0];

  assign bus.gnt_o    = w_sel;
  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = r_rdata;
  assign bus.err_o    = r_err;
  assign led_o        = r_led;
  assign irq_timer_o  = r_irq;

  // A software write to either mtime half wins over the tick for the whole 64-bit counter
  always_comb begin
    w_tick      = r_ctrl[0] && (r_ps_cnt == r_prescale);
    w_mtime_nxt = r_mtime;
    w_ps_nxt    = r_ps_cnt + 16'd1;
    if (w_wr_mt_lo || w_wr_mt_hi) begin
      if (w_wr_mt_lo) w_mtime_nxt[31:0]  = f_merge(r_mtime[31:0],  bus.wdata_i, bus.be_i);
      if (w_wr_mt_hi) w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], bus.wdata_i, bus.be_i);
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end
    if (w_wr_mt_lo || w_wr_mt_hi || w_wr_presc || !r_ctrl[0] || w_tick) begin
      w_ps_nxt = 16'd0;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      OffLed:   w_rdata = {28'd0, r_led};
      OffMtLo:  w_rdata = r_mtime[31:0];
      OffMtHi:  w_rdata = r_shadow;
      OffCmpLo: w_rdata = r_cmp[31:0];
      OffCmpHi: w_rdata = r_cmp[63:32];
      OffCtrl:  w_rdata = {30'd0, r_ctrl};
      OffPresc: w_rdata = {16'd0, r_prescale};
      default:  w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_led      <= 4'd0;
      r_mtime    <= 64'd0;
      r_shadow   <= 32'd0;
      r_cmp      <= {64{1'b1}};
      r_ctrl     <= 2'd0;
      r_prescale <= PrescaleRst;
      r_ps_cnt   <= 16'd0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_rvalid <= w_sel;
      r_err    <= w_sel && !w_hit_any;
      r_rdata  <= (w_rd && w_hit_any) ? w_rdata : 32'd0;
      r_mtime  <= w_mtime_nxt;
      r_ps_cnt <= w_ps_nxt;
      r_irq    <= r_ctrl[1] && (r_mtime >= r_cmp);
      // HI reads return this copy so a LO-then-HI pair is coherent
      if (w_rd && (w_off == OffMtLo)) r_shadow <= r_mtime[63:32];
      if (w_wr && (w_off == OffLed) && bus.be_i[0]) r_led <= bus.wdata_i[3:0];
      if (w_wr && (w_off == OffCtrl) && bus.be_i[0]) r_ctrl <= bus.wdata_i[1:0];
      if (w_wr && (w_off == OffCmpLo)) r_cmp[31:0]  <= f_merge(r_cmp[31:0],  bus.wdata_i, bus.be_i);
      if (w_wr && (w_off == OffCmpHi)) r_cmp[63:32] <= f_merge(r_cmp[63:32], bus.wdata_i, bus.be_i);
      if (w_wr_presc && bus.be_i[0]) r_prescale[7:0]  <= bus.wdata_i[7:0];
      if (w_wr_presc && bus.be_i[1]) r_prescale[15:8] <= bus.wdata_i[15:8];
    end
  end

endmodule

// File: doc/timer_led_periph.md
# timer_led_periph

Memory-mapped peripheral responder on the Ibex data port of the Arty A7 example system. It sits beside the SRAM on the core's data bus and answers req/gnt/rvalid transactions. It holds the LED register, which drives the board LEDs, and a 64-bit prescaled machine timer with compare that drives the core's `irq_timer_i`. The top level routes data requests here when the address falls inside the 4 kB window at `BaseAddr`.

## Interface
- `BaseAddr`, default 32'h0001_0000. Window base; must be 4 kB aligned.
- `PrescaleRst`, default 16'd0. Reset value of the PRESCALE register.
- `clk_sys`, input, 1. System clock.
- `rst_sys_n`, input, 1. Reset: asynchronous, active-low.
- `req_i`, input, 1. Data request from the core.
- `we_i`, input, 1. Write enable.
- `be_i`, input, 4. Byte enables.
- `addr_i`, input, 32. Byte address.
- `wdata_i`, input, 32. Write data.
- `gnt_o`, output, 1. Grant.
- `rvalid_o`, output, 1. Response valid.
- `rdata_o`, output, 32. Read data; valid while `rvalid_o` is high.
- `err_o`, output, 1. Error response; valid while `rvalid_o` is high.
- `led_o`, output, 4. LED register bits [3:0].
- `irq_timer_o`, output, 1. Timer interrupt, level-sensitive.

## Operation
- Select: `sel = req_i && (addr_i[31:12] == BaseAddr[31:12])`. Register offset is `addr_i[11:2]`; `addr_i[1:0]` is ignored.
- Unselected requests:
  - `gnt_o` stays 0.
  - No state changes.
  - No response is issued.
- Register map (byte offset):
  - 0x00 LED: RW, bits [3:0]; reads 0 above bit 3.
  - 0x04 MTIME_LO: RW.
  - 0x08 MTIME_HI: RW on write. A read returns the snapshot shadow, not the live counter.
  - 0x0C MTIMECMP_LO: RW.
  - 0x10 MTIMECMP_HI: RW.
  - 0x14 CTRL: RW. Bit 0 is EN (timer counting). Bit 1 is IE (interrupt enable).
  - 0x18 PRESCALE: RW, bits [15:0].
- Writes honour `be_i` per byte lane. With `be_i = 0` a write changes nothing but still completes with `err_o = 0`.
- Any other offset in the window returns `err_o = 1` and `rdata_o = 0`. Writes to such offsets have no effect.
- Snapshot: every read of MTIME_LO copies the live `mtime[63:32]` into the shadow in the same cycle the LO value is sampled. Software therefore reads LO, then HI, to get a coherent 64-bit value.
- Prescaler, 16-bit `ps_cnt`:
  - While EN=1, `ps_cnt` increments each cycle.
  - When `ps_cnt == PRESCALE`, `ps_cnt` returns to 0 and `mtime` increments by 1. The timer therefore ticks once every PRESCALE+1 cycles.
  - While EN=0, `ps_cnt` is held at 0 and `mtime` holds.
  - A write to PRESCALE, or to either MTIME half, clears `ps_cnt` to 0.
- `mtime` wraps from 2^64-1 to 0. The carry from LO to HI happens in the same tick.
- Simultaneous software write and increment on an MTIME half: the written byte lanes take the written value; no increment is applied to either half that cycle.
- Interrupt condition: `irq_d = IE && (mtime >= mtimecmp)`, an unsigned 64-bit compare. EN is not part of the condition.
- To clear the interrupt, software raises MTIMECMP or clears IE.

## Timing
- `gnt_o` is combinational: `gnt_o = sel`. Every selected request is granted in the cycle it is presented; there are no wait states.
- Response latency is exactly 1 cycle: `rvalid_o` is high in the cycle after the grant and low otherwise. Back-to-back requests produce back-to-back rvalids.
- `rdata_o` and `err_o` are registered together with `rvalid_o`. They are 0 whenever `rvalid_o` is 0.
- Register writes take effect at the clock edge that ends the grant cycle. A read in the very next request returns the new value.
- `irq_timer_o` is registered: it goes high 1 cycle after `irq_d` becomes true and low 1 cycle after it becomes false.
- `led_o` is driven directly from the LED register, so it updates at the grant-cycle edge.
- Reset values of the outputs:
  - `gnt_o` = 0 (`sel` is forced low while in reset).
  - `rvalid_o` = 0, `rdata_o` = 0, `err_o` = 0.
  - `led_o` = 0, `irq_timer_o` = 0.
- Reset values of internal state:
  - LED = 0, MTIME = 0, shadow = 0.
  - MTIMECMP = all ones, CTRL = 0.
  - PRESCALE = `PrescaleRst`, `ps_cnt` = 0.
- Reset asserted mid-transaction: any pending response is dropped, so no rvalid appears after reset is released.

## Test plan
- Write 0x0000_000A to 0x0001_0000 with `be_i=4'b0001`, then read it back:
  - Write: `gnt_o` in the same cycle, `led_o = 4'hA` on the next cycle.
  - Read: rvalid 1 cycle after grant, `rdata_o = 0x0000_000A`, `err_o = 0`.
- PRESCALE=3, CTRL=1, MTIME=0: after 40 cycles, a LO-then-HI read returns MTIME=10 ±1. `mtime` steps exactly every 4 cycles.
- Wrap and snapshot:
  - Write MTIME_HI = 0xFFFF_FFFF and MTIME_LO = 0xFFFF_FFFE with PRESCALE=0, EN=1.
  - After two ticks, `mtime` reads 0x0000_0000_0000_0000.
  - Reading LO just before the wrap yields shadow HI = 0xFFFF_FFFF, even though the live HI is 0 when HI is read.
- Set MTIMECMP=20, PRESCALE=0, CTRL=3 (EN=1, IE=1):
  - `irq_timer_o` rises 1 cycle after `mtime` reaches 20.
  - Writing MTIMECMP_LO = 1000 drops the interrupt 1 cycle later.
  - Clearing IE instead also drops it 1 cycle later.
- Read offset 0x1C and write offset 0x40:
  - Both get a grant, then rvalid with `err_o = 1` and `rdata_o = 0`.
  - No register changes.
- Access to 0x0002_0000 gets no grant and no rvalid. Asserting reset in the cycle after a grant means `rvalid_o` never appears and all outputs read 0.
